// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
//   Scans a 4x4 active-low matrix keypad one column at a time and debounces
//   the press and the release. Each accepted key becomes a single frame: the
//   code is held on button for HOLD_CYCLES, and key_valid pulses on the first
//   cycle. The most recent fingerprint byte is shown alongside the code.
//   Optional build macro: AUTO_REPEAT_EN. With it defined, a key that stays
//   held re-emits its code (fingerprint 0) every REPEAT_CYCLES after a frame ends.
module keypad_scan_encoder #(
  parameter int unsigned SCAN_DWELL      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 5,
  parameter int unsigned REPEAT_CYCLES   = 20
) (
  input  logic       sync_clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  input  logic [7:0] fp_data,
  input  logic       fp_valid,
  output logic [3:0] button,
  output logic [7:0] fingerprint,
  output logic       key_valid
);

  localparam int unsigned MAX_AB  = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
  localparam int unsigned MAX_CD  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_EMIT,
    S_WAIT_RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       sync1_q, sync2_q;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       fp_reg_q, fp_reg_d;
  logic [7:0]       fp_frame_q, fp_frame_d;
  logic             fp_keep_q, fp_keep_d;
`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] rep_q, rep_d;
`endif

  logic [3:0] rows_s;
  logic [3:0] latched_pat;
  logic [2:0] low_cnt;
  logic [1:0] low_row;
  logic       key_unmapped;

  assign rows_s       = sync2_q;
  assign latched_pat  = ~(4'b0001 << row_q);
  assign key_unmapped = (low_row == 2'd3) && (col_q == 2'd3);

  // Count low rows in the synchronized sample and remember which one is low
  always_comb begin
    low_cnt = '0;
    low_row = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!rows_s[r]) begin
        low_cnt = low_cnt + 3'd1;
        low_row = 2'(r);
      end
    end
  end

  // State register, row synchronizer and datapath registers
  always_ff @(posedge sync_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_SCAN;
      sync1_q    <= '1;
      sync2_q    <= '1;
      col_q      <= '0;
      row_q      <= '0;
      dwell_q    <= '0;
      cnt_q      <= '0;
      fp_reg_q   <= '0;
      fp_frame_q <= '0;
      fp_keep_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= row_in;
      sync2_q    <= sync1_q;
      col_q      <= col_d;
      row_q      <= row_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      fp_reg_q   <= fp_reg_d;
      fp_frame_q <= fp_frame_d;
      fp_keep_q  <= fp_keep_d;
`ifdef AUTO_REPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    fp_reg_d   = fp_reg_q;
    fp_frame_d = fp_frame_q;
    fp_keep_d  = fp_keep_q;
`ifdef AUTO_REPEAT_EN
    rep_d      = rep_q;
`endif

    if (fp_valid) begin
      fp_reg_d = fp_data;
    end

    unique case (state_q)
      S_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if ((low_cnt == 3'd1) && !key_unmapped) begin
            row_d   = low_row;
            cnt_d   = '0;
            state_d = S_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      S_DEBOUNCE: begin
        if (rows_s == latched_pat) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d      = '0;
            state_d    = S_EMIT;
            // A byte strobed on this very cycle is the latest one, so it wins.
            fp_frame_d = fp_reg_d;
            fp_keep_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          dwell_d = '0;
          col_d   = col_q + 2'd1;
          state_d = S_SCAN;
        end
      end

      S_EMIT: begin
        if (fp_valid) begin
          fp_keep_d = 1'b1;
        end
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_RELEASE;
`ifdef AUTO_REPEAT_EN
          rep_d   = '0;
`endif
          // Only a byte that arrived during this frame survives into the next one.
          if (!fp_valid && !fp_keep_q) begin
            fp_reg_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_RELEASE: begin
        if (rows_s[row_q]) begin
`ifdef AUTO_REPEAT_EN
          rep_d = '0;
`endif
          if (cnt_q == DEB_LAST) begin
            cnt_d   = '0;
            dwell_d = '0;
            col_d   = col_q + 2'd1;
            state_d = S_SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
`ifdef AUTO_REPEAT_EN
          if (rep_q == REP_LAST) begin
            rep_d      = '0;
            state_d    = S_EMIT;
            fp_frame_d = '0;
            fp_keep_d  = 1'b0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
`endif
        end
      end

      default: begin
        state_d = S_SCAN;
      end
    endcase
  end

  // Outputs decoded from registered state so reset clears them immediately
  always_comb begin
    col_out     = ~(4'b0001 << col_q);
    button      = '0;
    fingerprint = '0;
    key_valid   = 1'b0;
    if (state_q == S_EMIT) begin
      button      = {row_q, col_q} + 4'd1;
      fingerprint = fp_frame_q;
      key_valid   = (cnt_q == '0);
    end
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder
//   Keypad matrix model drives row_in from the set of pressed keys; a frame
//   monitor turns the button stream into frames, which each test compares with
//   frames predicted from the key map and the fingerprint rules.
//   Honours AUTO_REPEAT_EN the same way as the design.
module tb_keypad_scan_encoder;

  localparam int SCAN_DWELL      = 4;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int HOLD_CYCLES     = 5;
  localparam int REPEAT_CYCLES   = 20;
  localparam int LAT_MAX         = SCAN_DWELL + DEBOUNCE_CYCLES + 3;

  logic       sync_clk = 1'b0;
  logic       reset    = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] fp_data  = '0;
  logic       fp_valid = 1'b0;
  logic [3:0] button;
  logic [7:0] fingerprint;
  logic       key_valid;

  logic [15:0] pressed = '0;
  int compared   = 0;
  int mismatched = 0;
  int fp_pending = 0;

  keypad_scan_encoder #(
    .SCAN_DWELL      (SCAN_DWELL),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) dut (
    .sync_clk    (sync_clk),
    .reset       (reset),
    .row_in      (row_in),
    .col_out     (col_out),
    .fp_data     (fp_data),
    .fp_valid    (fp_valid),
    .button      (button),
    .fingerprint (fingerprint),
    .key_valid   (key_valid)
  );

  always #5 sync_clk = ~sync_clk;

  // Physical matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  typedef struct {
    int code;
    int len;
    int fp;
    bit kv_first;
    bit bad;
    int start;
  } frame_t;

  frame_t frames[$];
  frame_t cur;
  bit in_frame  = 0;
  bit have_prev = 0;
  int prev_end  = 0;
  int cycle     = 0;
  int gap_viol  = 0;
  int idle_viol = 0;
  int col_viol  = 0;

  always @(negedge sync_clk) begin
    cycle++;
    if (!(col_out == 4'b1110 || col_out == 4'b1101 || col_out == 4'b1011 || col_out == 4'b0111))
      col_viol++;
    if (reset) begin
      in_frame  = 0;
      have_prev = 0;
    end else if (button != 0) begin
      if (!in_frame) begin
        in_frame     = 1;
        cur.code     = int'(button);
        cur.len      = 1;
        cur.fp       = int'(fingerprint);
        cur.kv_first = key_valid;
        cur.bad      = 0;
        cur.start    = cycle;
        if (have_prev && (cycle - prev_end) < DEBOUNCE_CYCLES) gap_viol++;
      end else begin
        cur.len++;
        if (int'(button) != cur.code || int'(fingerprint) != cur.fp || key_valid) cur.bad = 1;
      end
    end else begin
      if (in_frame) begin
        frames.push_back(cur);
        in_frame  = 0;
        have_prev = 1;
        prev_end  = cycle;
      end
      if (fingerprint != 0 || key_valid) idle_viol++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sync_clk);
  endtask

  task automatic pulse_fp(input logic [7:0] v);
    fp_data  = v;
    fp_valid = 1'b1;
    @(negedge sync_clk);
    fp_valid = 1'b0;
  endtask

  task automatic wait_button(input bit nonzero, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if ((button != 0) == nonzero) begin
        ok = 1;
        break;
      end
      @(negedge sync_clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pressed = '0;
    tick(3);
    compared++;
    if (col_out !== 4'b1110 || button !== 4'd0 || fingerprint !== 8'd0 || key_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_hold: col=%b btn=%0d fp=%h kv=%b, expected col=1110 btn=0 fp=00 kv=0",
               col_out, button, fingerprint, key_valid);
    end
    reset = 1'b0;
    tick(1);
    compared++;
    if (col_out !== 4'b1110 || button !== 4'd0 || fingerprint !== 8'd0 || key_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: col=%b btn=%0d fp=%h kv=%b, expected col=1110 btn=0 fp=00 kv=0",
               col_out, button, fingerprint, key_valid);
    end
    fp_pending = 0;
    tick(10);
  endtask

  // Row0 held under column 1 for 40 cycles: a single frame with code 2
  task automatic test_single_key();
    frames.delete();
    pressed[1] = 1'b1;
    tick(40);
    pressed = '0;
    tick(20);
    compared++;
    if (frames.size() != 1) begin
      mismatched++;
      $display("FAIL single_count: got %0d frames, expected 1", frames.size());
    end else begin
      compared++;
      if (frames[0].code != 2 || frames[0].len != HOLD_CYCLES || frames[0].kv_first != 1'b1 ||
          frames[0].bad != 1'b0 || frames[0].fp != fp_pending) begin
        mismatched++;
        $display("FAIL single_frame: code=%0d len=%0d kv=%0b bad=%0b fp=%0h, expected code=2 len=%0d kv=1 bad=0 fp=%0h",
                 frames[0].code, frames[0].len, frames[0].kv_first, frames[0].bad, frames[0].fp,
                 HOLD_CYCLES, fp_pending);
      end
    end
    fp_pending = 0;
  endtask

  // Press exactly when a column's dwell begins and measure press-to-code time
  task automatic test_latency();
    logic [3:0] tgt, prev;
    int c, r, n;
    bit found, ok;
    c = $urandom_range(0, 3);
    r = $urandom_range(0, (c == 3) ? 2 : 3);
    tgt = ~(4'b0001 << c);
    frames.delete();
    found = 0;
    prev = col_out;
    for (int i = 0; i < 40; i++) begin
      @(negedge sync_clk);
      if (col_out == tgt && prev != tgt) begin
        found = 1;
        break;
      end
      prev = col_out;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL latency_colwait: col_out never moved to %b within 40 cycles", tgt);
    end
    pressed[4*r+c] = 1'b1;
    n = 0;
    while (button == 0 && n < 40) begin
      @(negedge sync_clk);
      n++;
    end
    compared++;
    if (n > LAT_MAX) begin
      mismatched++;
      $display("FAIL latency: key r%0d c%0d took %0d cycles, expected at most %0d", r, c, n, LAT_MAX);
    end
    wait_button(1'b0, 20, ok);
    pressed = '0;
    tick(20);
    compared++;
    if (frames.size() != 1 || frames[0].code != 4*r+c+1 || frames[0].len != HOLD_CYCLES ||
        frames[0].fp != fp_pending || frames[0].kv_first != 1'b1) begin
      mismatched++;
      $display("FAIL latency_frame: frames=%0d code=%0d len=%0d, expected 1 frame code=%0d len=%0d",
               frames.size(), (frames.size() > 0) ? frames[0].code : 0,
               (frames.size() > 0) ? frames[0].len : 0, 4*r+c+1, HOLD_CYCLES);
    end
    fp_pending = 0;
  endtask

  // Row1 glitches low for a short time: no code, scan moves to the next column
  task automatic test_bounce();
    logic [3:0] tgt, nxt, prev;
    int c, n;
    bit found;
    c = $urandom_range(0, 2);
    tgt = ~(4'b0001 << c);
    nxt = ~(4'b0001 << (c + 1));
    frames.delete();
    found = 0;
    prev = col_out;
    for (int i = 0; i < 40; i++) begin
      @(negedge sync_clk);
      if (col_out == tgt && prev != tgt) begin
        found = 1;
        break;
      end
      prev = col_out;
    end
    pressed[4+c] = 1'b1;
    tick(3);
    pressed = '0;
    n = 3;
    while (col_out == tgt && n < 20) begin
      @(negedge sync_clk);
      n++;
    end
    compared++;
    if (!found || col_out !== nxt || n < 5 || n > 8) begin
      mismatched++;
      $display("FAIL bounce_resume: found=%0b col=%b after %0d cycles, expected col=%b after 5..8",
               found, col_out, n, nxt);
    end
    tick(30);
    compared++;
    if (frames.size() != 0) begin
      mismatched++;
      $display("FAIL bounce_emit: got %0d frames, expected 0", frames.size());
    end
  endtask

  // Two rows in one column and the unmapped corner key are both ignored
  task automatic test_ignored();
    int c;
    c = $urandom_range(0, 3);
    frames.delete();
    pressed[c] = 1'b1;
    pressed[8+c] = 1'b1;
    tick(40);
    pressed = '0;
    tick(20);
    compared++;
    if (frames.size() != 0) begin
      mismatched++;
      $display("FAIL multi_row: got %0d frames for rows 0+2 col %0d, expected 0", frames.size(), c);
    end
    frames.delete();
    pressed[15] = 1'b1;
    tick(40);
    pressed = '0;
    tick(20);
    compared++;
    if (frames.size() != 0) begin
      mismatched++;
      $display("FAIL key33: got %0d frames, expected 0", frames.size());
    end
  endtask

  task automatic test_fingerprint();
    bit ok;
    logic [7:0] late;
    frames.delete();
    pulse_fp(8'h97);
    fp_pending = 'h97;
    tick(2);
    pressed[11] = 1'b1;
    wait_button(1'b1, 60, ok);
    compared++;
    if (!ok || button !== 4'd12 || fingerprint !== 8'h97 || key_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL fp_first: ok=%0b btn=%0d fp=%h kv=%b, expected btn=12 fp=97 kv=1",
               ok, button, fingerprint, key_valid);
    end
    wait_button(1'b0, 20, ok);
    pressed = '0;
    tick(20);
    fp_pending = 0;
    pressed[0] = 1'b1;
    wait_button(1'b1, 60, ok);
    // A byte strobed during this frame must not show now but must show next time
    late = 8'($urandom_range(1, 255));
    pulse_fp(late);
    wait_button(1'b0, 20, ok);
    pressed = '0;
    tick(20);
    pressed[5] = 1'b1;
    tick(40);
    pressed = '0;
    tick(20);
    compared++;
    if (frames.size() != 3) begin
      mismatched++;
      $display("FAIL fp_count: got %0d frames, expected 3", frames.size());
    end else begin
      compared++;
      if (frames[0].fp != 'h97 || frames[0].code != 12 || frames[0].len != HOLD_CYCLES || frames[0].bad) begin
        mismatched++;
        $display("FAIL fp_frame0: code=%0d fp=%0h len=%0d, expected code=12 fp=97 len=%0d",
                 frames[0].code, frames[0].fp, frames[0].len, HOLD_CYCLES);
      end
      compared++;
      if (frames[1].fp != 0 || frames[1].code != 1 || frames[1].bad) begin
        mismatched++;
        $display("FAIL fp_frame1: code=%0d fp=%0h bad=%0b, expected code=1 fp=0 bad=0",
                 frames[1].code, frames[1].fp, frames[1].bad);
      end
      compared++;
      if (frames[2].fp != int'(late) || frames[2].code != 6) begin
        mismatched++;
        $display("FAIL fp_frame2: code=%0d fp=%0h, expected code=6 fp=%0h",
                 frames[2].code, frames[2].fp, late);
      end
    end
    fp_pending = 0;
  endtask

  task automatic test_random();
    int kind, idx, c, r2, exp_fp;
    bit ok, mid;
    logic [7:0] v;
    for (int it = 0; it < 14; it++) begin
      frames.delete();
      kind = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) begin
        v = 8'($urandom);
        pulse_fp(v);
        fp_pending = int'(v);
        tick(2);
      end
      if (kind >= 2) begin
        idx = $urandom_range(0, 14);
        exp_fp = fp_pending;
        pressed[idx] = 1'b1;
        wait_button(1'b1, 60, ok);
        mid = 0;
        fp_pending = 0;
        if (ok && $urandom_range(0, 1) == 1) begin
          mid = 1;
          v = 8'($urandom);
          pulse_fp(v);
          fp_pending = int'(v);
        end
        wait_button(1'b0, 20, ok);
        tick($urandom_range(0, 10));
        pressed = '0;
        tick(20);
        compared++;
        if (frames.size() != 1 || frames[0].code != idx + 1 || frames[0].fp != exp_fp ||
            frames[0].len != HOLD_CYCLES || !frames[0].kv_first || frames[0].bad) begin
          mismatched++;
          $display("FAIL rand_key it%0d: frames=%0d code=%0d fp=%0h len=%0d, expected 1 frame code=%0d fp=%0h len=%0d mid=%0b",
                   it, frames.size(), (frames.size() > 0) ? frames[0].code : 0,
                   (frames.size() > 0) ? frames[0].fp : 0, (frames.size() > 0) ? frames[0].len : 0,
                   idx + 1, exp_fp, HOLD_CYCLES, mid);
        end
      end else begin
        if (kind == 0) begin
          c = $urandom_range(0, 3);
          r2 = $urandom_range(1, 3);
          pressed[c] = 1'b1;
          pressed[4*r2+c] = 1'b1;
        end else begin
          pressed[15] = 1'b1;
        end
        tick(40);
        pressed = '0;
        tick(20);
        compared++;
        if (frames.size() != 0) begin
          mismatched++;
          $display("FAIL rand_ignored it%0d kind%0d: got %0d frames, expected 0", it, kind, frames.size());
        end
      end
    end
  endtask

  // Reset in the middle of the frame for code 5
  task automatic test_reset_mid_frame();
    bit ok;
    frames.delete();
    pressed[4] = 1'b1;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (button == 4'd5) begin
        ok = 1;
        break;
      end
      @(negedge sync_clk);
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL midreset_wait: code 5 never appeared, button=%0d", button);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (button !== 4'd0 || col_out !== 4'b1110 || fingerprint !== 8'd0 || key_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_async: btn=%0d col=%b fp=%h kv=%b, expected btn=0 col=1110 fp=00 kv=0",
               button, col_out, fingerprint, key_valid);
    end
    pressed = '0;
    fp_pending = 0;
    tick(2);
    reset = 1'b0;
    tick(40);
    compared++;
    if (frames.size() != 0) begin
      mismatched++;
      $display("FAIL midreset_resume: got %0d frames after reset, expected 0", frames.size());
    end
  endtask

  // Key 7 held long; frames after the first repeat only with AUTO_REPEAT_EN
  task automatic test_hold_repeat();
    bit ok;
    int exp_n;
    frames.delete();
    pulse_fp(8'h5A);
    fp_pending = 'h5A;
    tick(2);
    pressed[6] = 1'b1;
    wait_button(1'b1, 60, ok);
    // Frames would start at s, s+25, s+50, s+75; release at s+90 stops the next one
    tick(90);
    pressed = '0;
    tick(30);
`ifdef AUTO_REPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    compared++;
    if (frames.size() != exp_n) begin
      mismatched++;
      $display("FAIL hold_count: got %0d frames, expected %0d", frames.size(), exp_n);
    end
    foreach (frames[i]) begin
      compared++;
      if (frames[i].code != 7 || frames[i].len != HOLD_CYCLES || !frames[i].kv_first || frames[i].bad ||
          frames[i].fp != ((i == 0) ? 'h5A : 0) ||
          (i > 0 && frames[i].start - frames[i-1].start != HOLD_CYCLES + REPEAT_CYCLES)) begin
        mismatched++;
        $display("FAIL hold_frame%0d: code=%0d len=%0d kv=%0b fp=%0h start=%0d, expected code=7 len=%0d kv=1 fp=%0h spacing=%0d",
                 i, frames[i].code, frames[i].len, frames[i].kv_first, frames[i].fp, frames[i].start,
                 HOLD_CYCLES, (i == 0) ? 'h5A : 0, HOLD_CYCLES + REPEAT_CYCLES);
      end
    end
    fp_pending = 0;
  endtask

  task automatic test_frame_rules();
    compared++;
    if (gap_viol != 0) begin
      mismatched++;
      $display("FAIL frame_gap: %0d gaps shorter than %0d idle cycles, expected 0", gap_viol, DEBOUNCE_CYCLES);
    end
    compared++;
    if (idle_viol != 0) begin
      mismatched++;
      $display("FAIL idle_outputs: %0d idle cycles with fingerprint or key_valid set, expected 0", idle_viol);
    end
    compared++;
    if (col_viol != 0) begin
      mismatched++;
      $display("FAIL col_onehot: %0d cycles without exactly one column low, expected 0", col_viol);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_key();
    test_latency();
    test_latency();
    test_bounce();
    test_ignored();
    test_fingerprint();
    test_random();
    test_reset_mid_frame();
    test_hold_repeat();
    test_frame_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
